// File: rtl/cipher_stream_loader_if.sv
// ----------------------------------------------------------------------------
// cipher_stream_loader_if
//
// Purpose:
//   Bundles the byte-stream receive link and the core-facing load outputs of
//   cipher_stream_loader into one interface.
//
// Signals:
//   rx_data          8            incoming byte
//   rx_valid         1            rx_data valid
//   rx_ready         1            loader accepts a byte this cycle
//   key_out          KEY_W        assembled key for the core
//   key_valid        1            one-cycle key strobe
//   plaintext_out    INPUT_WIDTH  assembled plaintext for the core
//   plaintext_valid  1            one-cycle plaintext strobe
//   key_loaded       1            sticky flag: a key has been issued since reset
//   frame_err        1            one-cycle error strobe
//
// Modports:
//   slave  - the loader (consumes rx bytes, produces the core outputs)
//   master - the byte source / core side (drives rx bytes, observes outputs)
// ----------------------------------------------------------------------------
interface cipher_stream_loader_if #(
    parameter int INPUT_WIDTH = 8
);
    localparam int KEY_W = INPUT_WIDTH * 4 + 2;

    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   rx_ready;
    logic [KEY_W-1:0]       key_out;
    logic                   key_valid;
    logic [INPUT_WIDTH-1:0] plaintext_out;
    logic                   plaintext_valid;
    logic                   key_loaded;
    logic                   frame_err;

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output key_out,
        output key_valid,
        output plaintext_out,
        output plaintext_valid,
        output key_loaded,
        output frame_err
    );

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  key_out,
        input  key_valid,
        input  plaintext_out,
        input  plaintext_valid,
        input  key_loaded,
        input  frame_err
    );
endinterface

// File: rtl/cipher_stream_loader.sv
// ----------------------------------------------------------------------------
// cipher_stream_loader
//
// Purpose:
//   Byte-stream front end for hybrid_chaotic_encryption. Decodes framed
//   commands arriving over a valid/ready byte link and assembles key and
//   plaintext words for the core, issuing single-cycle load strobes.
//   Frame format: header byte, then payload MSB-first.
//     0xA5 : key frame, KEY_BYTES payload bytes
//     0x5A : plaintext frame, PT_BYTES payload bytes (needs a loaded key)
//   Any other header, a plaintext frame without a key, or a stalled frame
//   produces a one-cycle frame_err strobe.
//
// Parameters:
//   INPUT_WIDTH     plaintext width (8/16/24/32); key width is INPUT_WIDTH*4+2
//   TIMEOUT_CYCLES  idle cycles tolerated mid-frame before abort; 0 disables
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   bus_if   slave modport of cipher_stream_loader_if (rx link + core outputs)
// ----------------------------------------------------------------------------
module cipher_stream_loader #(
    parameter int INPUT_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cipher_stream_loader_if.slave bus_if
);

    localparam int KEY_W     = INPUT_WIDTH * 4 + 2;
    localparam int KEY_BYTES = (KEY_W + 7) / 8;
    localparam int PT_BYTES  = (INPUT_WIDTH + 7) / 8;
    localparam int BW        = $clog2(KEY_BYTES + 1);
    localparam int CW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [7:0]    HDR_KEY    = 8'hA5;
    localparam logic [7:0]    HDR_PT     = 8'h5A;
    localparam logic [BW-1:0] KEY_LAST   = BW'(KEY_BYTES - 1);
    localparam logic [BW-1:0] PT_LAST    = BW'(PT_BYTES - 1);
    localparam logic [CW-1:0] IDLE_LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        KEY_LOAD = 2'd1,
        PT_LOAD  = 2'd2,
        EMIT     = 2'd3
    } state_e;

    state_e state_q, state_d;

    // The shift register keeps only the low KEY_W-8 bits of the previous
    // payload bytes: together with the byte being accepted this forms exactly
    // KEY_W bits, so surplus MSBs of the first key byte fall off naturally.
    logic [KEY_W-9:0]       shreg_q, shreg_d;
    logic [KEY_W-1:0]       assembled;
    logic [BW-1:0]          byte_cnt_q, byte_cnt_d;
    logic [CW-1:0]          idle_cnt_q, idle_cnt_d;
    logic                   discard_q, discard_d;
    logic                   emit_key_q, emit_key_d;
    logic [KEY_W-1:0]       key_q, key_d;
    logic [INPUT_WIDTH-1:0] pt_q, pt_d;
    logic                   key_loaded_q, key_loaded_d;
    logic                   frame_err_q, frame_err_d;

    logic rx_ready;
    logic xfer;
    logic in_load;
    logic last_byte;
    logic timeout_hit;

    // Handshake and frame-progress qualifiers. rx_ready is held low while
    // reset is asserted so every output reads 0 during reset.
    always_comb begin
        rx_ready    = rst_n && (state_q != EMIT);
        xfer        = bus_if.rx_valid && rx_ready;
        in_load     = (state_q == KEY_LOAD) || (state_q == PT_LOAD);
        last_byte   = ((state_q == KEY_LOAD) && (byte_cnt_q == KEY_LAST)) ||
                      ((state_q == PT_LOAD)  && (byte_cnt_q == PT_LAST));
        // A byte arriving in the final allowed cycle wins over the abort.
        timeout_hit = (TIMEOUT_CYCLES != 0) && in_load && !xfer &&
                      (idle_cnt_q == IDLE_LIMIT);
        assembled   = {shreg_q, bus_if.rx_data};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A discarded (key-less) plaintext frame returns
    // straight to IDLE because it has nothing to emit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (bus_if.rx_data == HDR_KEY) begin
                        state_d = KEY_LOAD;
                    end else if (bus_if.rx_data == HDR_PT) begin
                        state_d = PT_LOAD;
                    end
                end
            end
            KEY_LOAD, PT_LOAD: begin
                if (timeout_hit) begin
                    state_d = IDLE;
                end else if (xfer && last_byte) begin
                    state_d = ((state_q == PT_LOAD) && discard_q) ? IDLE : EMIT;
                end
            end
            EMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q      <= '0;
            byte_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            discard_q    <= 1'b0;
            emit_key_q   <= 1'b0;
            key_q        <= '0;
            pt_q         <= '0;
            key_loaded_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            byte_cnt_q   <= byte_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            discard_q    <= discard_d;
            emit_key_q   <= emit_key_d;
            key_q        <= key_d;
            pt_q         <= pt_d;
            key_loaded_q <= key_loaded_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Output logic: datapath next values, strobes and interface outputs.
    // The assembled word is captured on the edge accepting the last payload
    // byte, so key_out/plaintext_out already carry the new value during the
    // EMIT cycle in which the core sees the strobe. idle_cnt defaults to 0,
    // which clears it outside LOAD states, on LOAD entry and on every byte.
    always_comb begin
        shreg_d      = shreg_q;
        byte_cnt_d   = byte_cnt_q;
        idle_cnt_d   = '0;
        discard_d    = discard_q;
        emit_key_d   = emit_key_q;
        key_d        = key_q;
        pt_d         = pt_q;
        key_loaded_d = key_loaded_q;
        frame_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    shreg_d    = '0;
                    byte_cnt_d = '0;
                    if (bus_if.rx_data == HDR_KEY) begin
                        emit_key_d = 1'b1;
                        discard_d  = 1'b0;
                    end else if (bus_if.rx_data == HDR_PT) begin
                        emit_key_d  = 1'b0;
                        discard_d   = !key_loaded_q;
                        frame_err_d = !key_loaded_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            KEY_LOAD, PT_LOAD: begin
                if (timeout_hit) begin
                    shreg_d     = '0;
                    byte_cnt_d  = '0;
                    frame_err_d = 1'b1;
                end else if (xfer) begin
                    if (last_byte) begin
                        shreg_d    = '0;
                        byte_cnt_d = '0;
                        if (state_q == KEY_LOAD) begin
                            key_d        = assembled;
                            key_loaded_d = 1'b1;
                        end else if (!discard_q) begin
                            pt_d = assembled[INPUT_WIDTH-1:0];
                        end
                    end else begin
                        shreg_d    = assembled[KEY_W-9:0];
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: begin
            end
        endcase

        bus_if.rx_ready        = rx_ready;
        bus_if.key_valid       = (state_q == EMIT) && emit_key_q;
        bus_if.plaintext_valid = (state_q == EMIT) && !emit_key_q;
        bus_if.key_out         = key_q;
        bus_if.plaintext_out   = pt_q;
        bus_if.key_loaded      = key_loaded_q;
        bus_if.frame_err       = frame_err_q;
    end

endmodule
